// File: rtl/key_event_scanner_if.sv
// Keypad scanner bundle: matrix rows/columns plus the key_code valid/ready handshake.
// The master is the scanner; the slave drives the rows and consumes keys.
interface key_event_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_overrun;

  modport master (
    input  row,
    input  key_ready,
    output col,
    output key_code,
    output key_valid,
    output key_overrun
  );

  modport slave (
    output row,
    output key_ready,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_overrun
  );
endinterface

// File: rtl/key_event_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and a one-deep key
// holding register; a key confirmed while the register is still full is dropped.
module key_event_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 16
) (
  input logic               clk,
  input logic               reset,
  key_event_scanner_if.master kif
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e           state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       cand_q, cand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             sample;
  logic             one_low;
  logic             all_high;
  logic [1:0]       row_idx;
  logic [CntW-1:0]  cnt_inc;
  logic             cnt_done;
  logic             confirm;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    unique case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign sample   = (slot_q == SlotW'(SCAN_DIV - 1));
  assign all_high = (kif.row == 4'hF);
  assign cnt_inc  = cnt_q + CntW'(1);
  assign cnt_done = (cnt_inc == CntW'(DEBOUNCE_CNT));

  // One-low detection on the live rows; the candidate's row index reuses the same decode.
  always_comb begin
    one_low = 1'b1;
    unique case (kif.row)
      4'b1110: ;
      4'b1101: ;
      4'b1011: ;
      4'b0111: ;
      default: one_low = 1'b0;
    endcase
    unique case (cand_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = sample ? '0 : slot_q + SlotW'(1);
    col_idx_d = col_idx_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    confirm   = 1'b0;

    if (sample) begin
      unique case (state_q)
        StScan: begin
          if (one_low) begin
            cand_d  = kif.row;
            cnt_d   = CntW'(1);
            state_d = StDebounce;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        StDebounce: begin
          if (kif.row == cand_q) begin
            if (cnt_done) begin
              confirm = 1'b1;
              cnt_d   = '0;
              state_d = StHeld;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = StScan;
          end
        end
        StHeld: begin
          if (all_high) begin
            cnt_d   = CntW'(1);
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (!all_high) begin
            cnt_d   = '0;
            state_d = StHeld;
          end else if (cnt_done) begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = StScan;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  // Output register: a transfer and a reload on the same edge leave valid set.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && kif.key_ready) begin
      valid_d = 1'b0;
    end
    if (confirm) begin
      if (!valid_q || kif.key_ready) begin
        code_d  = key_map(row_idx, col_idx_q);
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StScan;
      slot_q    <= '0;
      col_idx_q <= 2'd0;
      cand_q    <= 4'hF;
      cnt_q     <= '0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      col_idx_q <= col_idx_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign kif.col         = ~(4'b0001 << col_idx_q);
  assign kif.key_code    = code_q;
  assign kif.key_valid   = valid_q;
  assign kif.key_overrun = ovr_q;

endmodule

// File: tb/tb_key_event_scanner.sv
// Bench for key_event_scanner: a physical keypad model drives the rows from the
// column lines, and expectations come from sample counting and press timing.
module tb_key_event_scanner;
  localparam int SD  = 4;
  localparam int DEB = 3;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [15:0] pressed;
  logic [3:0]  row_drv;
  logic [3:0]  kmap [16];

  int cyc;
  int exp_col;
  int det;
  int vhigh;
  int total;
  int bad;

  key_event_scanner_if kif ();

  key_event_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DEB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kif  (kif)
  );

  // Keypad: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kif.col[c]) row_drv[r] = 1'b0;
      end
    end
  end
  assign kif.row       = row_drv;
  assign kif.key_ready = ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] colv(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (kif.key_valid === 1'b1) vhigh++;
  endtask

  // Idle scanning with no key down: the column steps once per sample.
  task automatic idle(input int n, input bool_chk);
    for (int i = 0; i < n; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
      if (cyc % SD == 0) exp_col = (exp_col + 1) % 4;
      if (bool_chk) chk("idle_col", kif.col, colv(exp_col));
    end
  endtask

  task automatic scan_until(input int c);
    int found = 0;
    int n = 0;
    while (found == 0 && n < 60) begin
      tick();
      n++;
      if (cyc % SD == 0) begin
        if (exp_col == c) found = 1;
        exp_col = (exp_col + 1) % 4;
      end
    end
    chk("scan_reach", found, 1);
  endtask

  task automatic wait_detect(input int c);
    int found = 0;
    int n = 0;
    while (found == 0 && n < 60) begin
      tick();
      n++;
      if (cyc % SD == 0) begin
        if (exp_col == c) begin
          found = 1;
          det   = cyc;
        end else begin
          exp_col = (exp_col + 1) % 4;
        end
      end
    end
    chk("detect", found, 1);
    chk("detect_col", kif.col, colv(exp_col));
  endtask

  task automatic wait_samples(input int n);
    int k = 0;
    while (k < n) begin
      tick();
      if (cyc % SD == 0) k++;
    end
  endtask

  // Run to the confirm edge, (DEB-1)*SD cycles after detection.
  task automatic confirm(input logic [3:0] exp_code, input bit exp_ovr);
    logic pre_valid;
    while (cyc < det + (DEB - 1) * SD - 1) tick();
    pre_valid = kif.key_valid;
    chk("pre_confirm_ovr", kif.key_overrun, 1'b0);
    if (!exp_ovr && ready) chk("pre_confirm_valid", kif.key_valid, 1'b0);
    tick();
    chk("confirm_valid", kif.key_valid, 1'b1);
    chk("confirm_code", kif.key_code, exp_code);
    chk("confirm_ovr", kif.key_overrun, exp_ovr);
    if (ready && !exp_ovr && !pre_valid) begin
      tick();
      chk("valid_pulse", kif.key_valid, 1'b0);
    end else begin
      tick();
      chk("ovr_one_cycle", kif.key_overrun, 1'b0);
    end
  endtask

  task automatic settle(input int c);
    pressed = '0;
    wait_samples(DEB);
    exp_col = (c + 1) % 4;
    chk("release_col", kif.col, colv(exp_col));
  endtask

  initial begin
    int r, c;
    kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    total   = 0;
    bad     = 0;
    vhigh   = 0;
    det     = 0;
    pressed = '0;
    ready   = 1'b0;
    reset   = 1'b1;
    #12;
    chk("rst_col", kif.col, 4'b1110);
    chk("rst_valid", kif.key_valid, 1'b0);
    chk("rst_code", kif.key_code, 4'h0);
    chk("rst_ovr", kif.key_overrun, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    cyc     = 0;
    exp_col = 0;

    // Idle: column rotates every SD cycles, first step at cycle SD.
    vhigh = 0;
    idle(32, 1'b1);
    chk("idle_no_key", vhigh, 0);

    // '5' held long with ready high: one event, no repeats while held.
    ready   = 1'b1;
    pressed = key(1, 1);
    wait_detect(1);
    confirm(4'h5, 1'b0);
    vhigh = 0;
    wait_samples(6);
    chk("hold_no_repeat", vhigh, 0);
    chk("hold_col", kif.col, colv(1));
    settle(1);

    // '9' bounces after detection, then presses cleanly.
    pressed = key(2, 2);
    wait_detect(2);
    pressed = '0;
    wait_samples(1);
    exp_col = 3;
    chk("bounce_col", kif.col, colv(exp_col));
    chk("bounce_valid", kif.key_valid, 1'b0);
    pressed = key(2, 2);
    wait_detect(2);
    confirm(4'h9, 1'b0);
    settle(2);

    // Two rows low in column 3 are ignored; a single row 3 then gives 'D'.
    pressed = key(0, 3) | key(2, 3);
    vhigh = 0;
    scan_until(3);
    chk("multi_col", kif.col, colv(0));
    chk("multi_no_key", vhigh, 0);
    pressed = key(3, 3);
    wait_detect(3);
    confirm(4'hD, 1'b0);
    settle(3);

    // Random keys pressed at random times.
    for (int it = 0; it < 6; it++) begin
      idle($urandom_range(0, 12), 1'b0);
      ready   = 1'b1;
      r       = $urandom_range(0, 3);
      c       = $urandom_range(0, 3);
      pressed = key(r, c);
      wait_detect(c);
      confirm(kmap[r*4+c], 1'b0);
      vhigh = 0;
      wait_samples($urandom_range(1, 4));
      chk("rnd_no_repeat", vhigh, 0);
      settle(c);
    end

    // Overrun: 'F' stays pending while '1' is dropped.
    ready   = 1'b0;
    pressed = key(3, 2);
    wait_detect(2);
    confirm(4'hF, 1'b0);
    settle(2);
    chk("pending_valid", kif.key_valid, 1'b1);
    pressed = key(0, 0);
    wait_detect(0);
    confirm(4'hF, 1'b1);
    settle(0);
    chk("pending_code", kif.key_code, 4'hF);
    ready = 1'b1;
    tick();
    chk("transfer_valid", kif.key_valid, 1'b0);

    // Reset while a key is pending and '0' is mid-debounce.
    ready   = 1'b0;
    pressed = key(2, 0);
    wait_detect(0);
    confirm(4'h7, 1'b0);
    settle(0);
    pressed = key(3, 1);
    wait_detect(1);
    wait_samples(1);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_valid", kif.key_valid, 1'b0);
    chk("midrst_col", kif.col, 4'b1110);
    chk("midrst_code", kif.key_code, 4'h0);
    pressed = '0;
    #10;
    reset   = 1'b0;
    cyc     = 0;
    exp_col = 0;
    vhigh   = 0;
    idle(40, 1'b1);
    chk("no_stale_event", vhigh, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
